// File: rtl/mem_access_unit.sv
// mem_access_unit: valid/ready MEM stage with load formatting, store enables, alignment/bus exceptions, flush and timeout
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int RAW = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_sdata,
  input  logic              in_rf_we,
  input  logic [RAW-1:0]    in_rf_waddr,
  input  logic              flush,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [3:0]        dreq_wen,
  output logic [31:0]       dreq_wdata,
  input  logic              dresp_valid,
  input  logic [31:0]       dresp_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_pc,
  output logic              wb_we,
  output logic [RAW-1:0]    wb_waddr,
  output logic [31:0]       wb_wdata,
  output logic [1:0]        wb_exc,
  output logic [ADDR_W-1:0] wb_badvaddr,
  output logic              stall_req,
  output logic              fwd_we,
  output logic [RAW-1:0]    fwd_waddr,
  output logic [31:0]       fwd_wdata,
  output logic              fwd_pending
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 2);
  state_t state;
  logic [CW-1:0] cnt;
  logic drop, we_q;
  logic [3:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] sdata_q, pc_q, sh, ld_data;
  logic [RAW-1:0] waddr_q;
  logic in_ld, in_st, in_mis, hit, sgn;
  logic [1:0] in_sz, q_sz;
  logic [7:0] lb_v;
  logic [15:0] lh_v;
  function automatic logic [1:0] sz_of(input logic [3:0] op);
    return (op == 4'd1 || op == 4'd2 || op == 4'd9) ? 2'd0 :
           (op == 4'd3 || op == 4'd4 || op == 4'd10) ? 2'd1 : 2'd2;
  endfunction
  always_comb begin
    in_ld = in_op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    in_st = in_op inside {4'd9, 4'd10, 4'd11};
    in_sz = sz_of(in_op);
    in_mis = (in_ld | in_st) & ((in_sz == 2'd1 & in_addr[0]) | (in_sz == 2'd2 & in_addr[1:0] != 2'b00));
    q_sz = sz_of(op_q);
    hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    sh = dresp_rdata >> {addr_q[1:0], 3'b000};
    lb_v = sh[7:0];
    lh_v = addr_q[1] ? dresp_rdata[31:16] : dresp_rdata[15:0];
    sgn = op_q == 4'd1 || op_q == 4'd3;
    ld_data = q_sz == 2'd0 ? {{24{sgn & lb_v[7]}}, lb_v} :
              q_sz == 2'd1 ? {{16{sgn & lh_v[15]}}, lh_v} : dresp_rdata;
    in_ready = state == IDLE;
    stall_req = state != IDLE;
    dreq_valid = state == REQ;
    dreq_addr = {addr_q[ADDR_W-1:2], 2'b00};
    dreq_wen = !op_q[3] ? 4'b0000 :
               q_sz == 2'd0 ? 4'b0001 << addr_q[1:0] :
               q_sz == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dreq_wdata = q_sz == 2'd0 ? {4{sdata_q[7:0]}} : q_sz == 2'd1 ? {2{sdata_q[15:0]}} : sdata_q;
    fwd_pending = state != IDLE;
    fwd_we = fwd_pending ? we_q & ~op_q[3] : wb_we;
    fwd_waddr = fwd_pending ? waddr_q : wb_waddr;
    fwd_wdata = wb_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      drop <= 1'b0;
      op_q <= '0;
      addr_q <= '0;
      sdata_q <= '0;
      pc_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wb_valid <= 1'b0;
      wb_pc <= '0;
      wb_we <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      wb_exc <= 2'd0;
      wb_badvaddr <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_exc <= 2'd0;
      case (state)
        IDLE: if (in_valid && !flush) begin
          if (!(in_ld || in_st)) begin
            wb_valid <= 1'b1;
            wb_pc <= in_pc;
            wb_we <= in_rf_we;
            wb_waddr <= in_rf_waddr;
            wb_wdata <= 32'(in_addr);
          end else if (in_mis) begin
            wb_valid <= 1'b1;
            wb_pc <= in_pc;
            wb_exc <= in_st ? 2'd2 : 2'd1;
            wb_badvaddr <= in_addr;
          end else begin
            state <= REQ;
            cnt <= '0;
            drop <= 1'b0;
            op_q <= in_op;
            addr_q <= in_addr;
            sdata_q <= in_sdata;
            pc_q <= in_pc;
            we_q <= in_rf_we;
            waddr_q <= in_rf_waddr;
          end
        end
        REQ: if (dreq_ready) begin
          state <= RESP;
          drop <= flush;
          cnt <= cnt + CW'(1);
        end else if (flush) begin
          state <= IDLE;
        end else if (hit) begin
          state <= IDLE;
          wb_valid <= 1'b1;
          wb_exc <= 2'd3;
          wb_pc <= pc_q;
          wb_badvaddr <= addr_q;
        end else begin
          cnt <= cnt + CW'(1);
        end
        RESP: if (dresp_valid) begin
          state <= IDLE;
          if (!drop && !flush) begin
            wb_valid <= 1'b1;
            wb_pc <= pc_q;
            wb_we <= we_q & ~op_q[3];
            wb_waddr <= waddr_q;
            if (!op_q[3]) wb_wdata <= ld_data;
          end
        end else if (hit) begin
          state <= IDLE;
          if (!drop && !flush) begin
            wb_valid <= 1'b1;
            wb_exc <= 2'd3;
            wb_pc <= pc_q;
            wb_badvaddr <= addr_q;
          end
        end else begin
          cnt <= cnt + CW'(1);
          drop <= drop | flush;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven and hand-sequenced checks of mem_access_unit
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_rf_we = 1'b0, flush = 1'b0, dreq_ready = 1'b1, dresp_valid = 1'b0;
  logic [31:0] in_pc = '0, in_addr = '0, in_sdata = '0, dresp_rdata = '0;
  logic [3:0] in_op = '0;
  logic [4:0] in_rf_waddr = '0;
  logic in_ready, dreq_valid, wb_valid, wb_we, stall_req, fwd_we, fwd_pending;
  logic [31:0] dreq_addr, dreq_wdata, wb_pc, wb_wdata, wb_badvaddr, fwd_wdata;
  logic [3:0] dreq_wen;
  logic [4:0] wb_waddr, fwd_waddr;
  logic [1:0] wb_exc;
  logic t_in_ready, t_dreq_valid, t_wb_valid, t_wb_we, t_stall_req, t_fwd_we, t_fwd_pending;
  logic [31:0] t_dreq_addr, t_dreq_wdata, t_wb_pc, t_wb_wdata, t_wb_badvaddr, t_fwd_wdata;
  logic [3:0] t_dreq_wen;
  logic [4:0] t_wb_waddr, t_fwd_waddr;
  logic [1:0] t_wb_exc;
  int n_cmp = 0, n_err = 0;
  localparam logic [31:0] RD = 32'h80AA55CC;
  always #5 clk = ~clk;
  mem_access_unit u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
    .in_addr(in_addr), .in_sdata(in_sdata), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr), .dreq_wen(dreq_wen),
    .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_exc(wb_exc),
    .wb_badvaddr(wb_badvaddr), .stall_req(stall_req), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending)
  );
  mem_access_unit #(.TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .in_pc(in_pc), .in_op(in_op),
    .in_addr(in_addr), .in_sdata(in_sdata), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .flush(flush),
    .dreq_valid(t_dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(t_dreq_addr), .dreq_wen(t_dreq_wen),
    .dreq_wdata(t_dreq_wdata), .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .wb_valid(t_wb_valid),
    .wb_pc(t_wb_pc), .wb_we(t_wb_we), .wb_waddr(t_wb_waddr), .wb_wdata(t_wb_wdata), .wb_exc(t_wb_exc),
    .wb_badvaddr(t_wb_badvaddr), .stall_req(t_stall_req), .fwd_we(t_fwd_we), .fwd_waddr(t_fwd_waddr),
    .fwd_wdata(t_fwd_wdata), .fwd_pending(t_fwd_pending)
  );
  typedef struct {
    logic [3:0] op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic mem;
    logic [3:0] wen;
    logic [31:0] wdata;
    logic we;
    logic [31:0] wbd;
    logic [1:0] exc;
  } vec_t;
  vec_t v[18];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] pc, input logic [4:0] wa);
    in_valid = 1'b1;
    in_op = op;
    in_addr = addr;
    in_pc = pc;
    in_rf_we = 1'b1;
    in_rf_waddr = wa;
    in_sdata = 32'h1234ABCD;
    step();
    in_valid = 1'b0;
    in_op = 4'd0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    v[0]  = '{4'd1,  32'h103, 32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'hFFFFFF80, 2'd0};
    v[1]  = '{4'd2,  32'h103, 32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'h00000080, 2'd0};
    v[2]  = '{4'd3,  32'h102, 32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'hFFFF80AA, 2'd0};
    v[3]  = '{4'd4,  32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'h000055CC, 2'd0};
    v[4]  = '{4'd1,  32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'hFFFFFFCC, 2'd0};
    v[5]  = '{4'd2,  32'h101, 32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'h00000055, 2'd0};
    v[6]  = '{4'd3,  32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'h000055CC, 2'd0};
    v[7]  = '{4'd5,  32'h104, 32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'h80AA55CC, 2'd0};
    v[8]  = '{4'd11, 32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 2'd0};
    v[9]  = '{4'd10, 32'h102, 32'h1234ABCD, 1'b1, 4'hC, 32'hABCDABCD, 1'b0, 32'h0, 2'd0};
    v[10] = '{4'd10, 32'h100, 32'h1234ABCD, 1'b1, 4'h3, 32'hABCDABCD, 1'b0, 32'h0, 2'd0};
    v[11] = '{4'd9,  32'h101, 32'h123456A5, 1'b1, 4'h2, 32'hA5A5A5A5, 1'b0, 32'h0, 2'd0};
    v[12] = '{4'd0,  32'h12345678, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h12345678, 2'd0};
    v[13] = '{4'd7,  32'hCAFE, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0000CAFE, 2'd0};
    v[14] = '{4'd5,  32'h101, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd1};
    v[15] = '{4'd10, 32'h103, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd2};
    v[16] = '{4'd11, 32'h102, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd2};
    v[17] = '{4'd3,  32'h101, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd1};
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_exc", wb_exc, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_op = v[i].op;
      in_addr = v[i].addr;
      in_sdata = v[i].sdata;
      in_pc = 32'h400 + 32'(i * 4);
      in_rf_we = 1'b1;
      in_rf_waddr = 5'(i + 1);
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), in_ready, 1);
      step();
      in_valid = 1'b0;
      in_op = 4'd0;
      if (v[i].mem) begin
        @(negedge clk);
        chk($sformatf("v%0d dreq_valid", i), dreq_valid, 1);
        chk($sformatf("v%0d dreq_addr", i), dreq_addr, v[i].addr & 32'hFFFFFFFC);
        chk($sformatf("v%0d dreq_wen", i), dreq_wen, v[i].wen);
        if (v[i].wen != 4'h0) chk($sformatf("v%0d dreq_wdata", i), dreq_wdata, v[i].wdata);
        chk($sformatf("v%0d stall1", i), stall_req, 1);
        chk($sformatf("v%0d fwd_pending", i), fwd_pending, 1);
        step();
        dresp_valid = 1'b1;
        dresp_rdata = RD;
        @(negedge clk);
        chk($sformatf("v%0d stall2", i), stall_req, 1);
        chk($sformatf("v%0d early_wb", i), wb_valid, 0);
        step();
        dresp_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("v%0d wb_valid", i), wb_valid, 1);
      chk($sformatf("v%0d wb_exc", i), wb_exc, v[i].exc);
      chk($sformatf("v%0d wb_we", i), wb_we, v[i].we);
      chk($sformatf("v%0d wb_pc", i), wb_pc, 32'h400 + 32'(i * 4));
      chk($sformatf("v%0d dreq_idle", i), dreq_valid, 0);
      chk($sformatf("v%0d in_ready_wb", i), in_ready, 1);
      if (v[i].exc != 2'd0) chk($sformatf("v%0d badvaddr", i), wb_badvaddr, v[i].addr);
      if (v[i].we) begin
        chk($sformatf("v%0d wb_wdata", i), wb_wdata, v[i].wbd);
        chk($sformatf("v%0d wb_waddr", i), wb_waddr, 32'(i + 1));
        chk($sformatf("v%0d fwd_wdata", i), fwd_wdata, v[i].wbd);
        chk($sformatf("v%0d fwd_pend0", i), fwd_pending, 0);
      end
      step();
      @(negedge clk);
      chk($sformatf("v%0d pulse", i), wb_valid, 0);
      step();
    end
    issue(4'd5, 32'h200, 32'h500, 5'd7);
    step();
    @(negedge clk);
    chk("fr_fwd_pending", fwd_pending, 1);
    chk("fr_fwd_waddr", fwd_waddr, 7);
    chk("fr_fwd_we", fwd_we, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fr_wb_after_flush", wb_valid, 0);
    chk("fr_stall", stall_req, 1);
    step();
    step();
    dresp_valid = 1'b1;
    dresp_rdata = RD;
    @(negedge clk);
    chk("fr_in_ready_resp", in_ready, 0);
    step();
    dresp_valid = 1'b0;
    @(negedge clk);
    chk("fr_in_ready_back", in_ready, 1);
    chk("fr_no_wb1", wb_valid, 0);
    step();
    @(negedge clk);
    chk("fr_no_wb2", wb_valid, 0);
    step();
    dreq_ready = 1'b0;
    issue(4'd5, 32'h204, 32'h504, 5'd8);
    @(negedge clk);
    chk("fq_dreq_valid", dreq_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fq_dreq_dropped", dreq_valid, 0);
    chk("fq_in_ready", in_ready, 1);
    chk("fq_no_wb", wb_valid, 0);
    dreq_ready = 1'b1;
    step();
    in_valid = 1'b1;
    in_op = 4'd0;
    in_addr = 32'h77;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("fi_no_wb", wb_valid, 0);
    chk("fi_in_ready", in_ready, 1);
    step();
    dreq_ready = 1'b0;
    issue(4'd4, 32'h102, 32'h510, 5'd9);
    @(negedge clk);
    chk("ws_addr1", dreq_addr, 32'h100);
    chk("ws_wen", dreq_wen, 0);
    step();
    @(negedge clk);
    chk("ws_valid2", dreq_valid, 1);
    chk("ws_addr2", dreq_addr, 32'h100);
    step();
    dreq_ready = 1'b1;
    step();
    dresp_valid = 1'b1;
    dresp_rdata = RD;
    step();
    dresp_valid = 1'b0;
    @(negedge clk);
    chk("ws_wb_valid", wb_valid, 1);
    chk("ws_wb_wdata", wb_wdata, 32'h000080AA);
    chk("ws_wb_waddr", wb_waddr, 9);
    step();
    step();
    dreq_ready = 1'b0;
    issue(4'd5, 32'h300, 32'h600, 5'd10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", k), t_wb_valid, 0);
      chk($sformatf("to_stall%0d", k), t_stall_req, 1);
      step();
    end
    @(negedge clk);
    chk("to_req4", t_dreq_valid, 1);
    chk("to_wait3", t_wb_valid, 0);
    step();
    @(negedge clk);
    chk("to_wb_valid", t_wb_valid, 1);
    chk("to_wb_exc", t_wb_exc, 3);
    chk("to_wb_we", t_wb_we, 0);
    chk("to_badvaddr", t_wb_badvaddr, 32'h300);
    chk("to_pc", t_wb_pc, 32'h600);
    chk("to_in_ready", t_in_ready, 1);
    step();
    dresp_valid = 1'b1;
    dresp_rdata = RD;
    @(negedge clk);
    chk("to_pulse", t_wb_valid, 0);
    step();
    dresp_valid = 1'b0;
    @(negedge clk);
    chk("to_late_resp", t_wb_valid, 0);
    chk("to_idle", t_in_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
